seg_display_ctrl: RTL and testbench

//  Parametrised successor to the processor-output display driver. Captures NCH

---
 rtl/display_pkg.sv | 13 +
 rtl/bin2bcd_seq.sv | 47 ++++
 rtl/seg_display_ctrl.sv | 131 +++++++++++++
 tb/tb_seg_display_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg: seven-segment font and controller state shared by the display blocks.
package display_pkg;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    localparam logic [7:0] SEG_HEX [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

    typedef enum logic [1:0] {IDLE, CAPTURE, CONV, COMMIT} state_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble; start loads and performs the first shift,
// done pulses the cycle after the W-th shift.
module bin2bcd_seq #(
    parameter int W   = 16,
    parameter int DPC = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [W-1:0]     bin,
    output logic [4*DPC-1:0] bcd,
    output logic             done
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]     sr;
    logic [CW-1:0]    cnt;
    logic [4*DPC-1:0] adj;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < DPC; i++)
            if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sr   <= '0;
            bcd  <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                sr  <= bin << 1;
                bcd <= {{(4*DPC-1){1'b0}}, bin[W-1]};
                cnt <= CW'(W - 1);
            end else if (cnt != '0) begin
                {bcd, sr} <= {adj[4*DPC-2:0], sr, 1'b0};
                cnt       <= cnt - CW'(1);
                done      <= (cnt == CW'(1));
            end
        end
    end

endmodule

// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: captures NCH channel values, converts them to hex/decimal digits
// in a shadow frame, commits the frame atomically and scans it onto one segment bus.
module seg_display_ctrl
    import display_pkg::*;
#(
    parameter int W        = 16,
    parameter int NCH      = 2,
    parameter int DPC      = 5,
    parameter int SCAN_DIV = 4096
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NCH*W-1:0]   val_in,
    input  logic               load,
    input  logic               dec_mode,
    input  logic               lz_blank,
    output logic [7:0]         seg_out,
    output logic [NCH*DPC-1:0] seg_sel,
    output logic               busy
);

    localparam int ND  = NCH * DPC;
    localparam int BW  = 4 * DPC;
    localparam int CHW = NCH > 1 ? $clog2(NCH) : 1;
    localparam int PW  = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int DW  = ND > 1 ? $clog2(ND) : 1;

    state_t           state, state_d;
    logic [NCH*W-1:0] cur_val, hold_val;
    logic             cur_dec, cur_lz, hold_dec, hold_lz, pending;
    logic [CHW-1:0]   ch, conv_idx;
    logic [BW-1:0]    shadow [NCH];
    logic [7:0]       disp [ND];
    logic [7:0]       disp_d [ND];
    logic [PW-1:0]    pre;
    logic [DW-1:0]    pos, pos_d;
    logic             start, done, relatch, take, step;
    logic [BW-1:0]    bcd, hex_dig;

    // The next channel's conversion is launched while the current result is stored,
    // so each decimal channel costs exactly W cycles.
    assign conv_idx = (state == CAPTURE) ? '0 : ch + CHW'(1);
    assign hex_dig  = BW'(cur_val[ch*W +: W]);
    assign step     = state == CONV && (!cur_dec || done);
    assign take     = (state == IDLE && load) || relatch;
    assign busy     = state != IDLE;

    bin2bcd_seq #(.W(W), .DPC(DPC)) u_bcd (
        .clock (clock),
        .reset (reset),
        .start (start),
        .bin   (cur_val[conv_idx*W +: W]),
        .bcd   (bcd),
        .done  (done)
    );

    always_comb begin
        state_d = state;
        start   = 1'b0;
        relatch = 1'b0;
        case (state)
            IDLE:    state_d = load ? CAPTURE : IDLE;
            CAPTURE: begin
                state_d = CONV;
                start   = cur_dec;
            end
            CONV: if (step) begin
                state_d = (ch == CHW'(NCH - 1)) ? COMMIT : CONV;
                start   = cur_dec && ch != CHW'(NCH - 1);
            end
            COMMIT: begin
                relatch = load || pending;
                state_d = relatch ? CAPTURE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            ch       <= '0;
            pending  <= 1'b0;
            cur_val  <= '0;
            cur_dec  <= 1'b0;
            cur_lz   <= 1'b0;
            hold_val <= '0;
            hold_dec <= 1'b0;
            hold_lz  <= 1'b0;
            for (int c = 0; c < NCH; c++) shadow[c] <= '0;
        end else begin
            state <= state_d;
            if (take)
                {cur_val, cur_dec, cur_lz} <= load ? {val_in, dec_mode, lz_blank}
                                                   : {hold_val, hold_dec, hold_lz};
            if (load && state != IDLE) {hold_val, hold_dec, hold_lz} <= {val_in, dec_mode, lz_blank};
            pending <= (state == COMMIT) ? 1'b0 : pending | (load && state != IDLE);
            ch      <= (state == CAPTURE) ? '0 : step ? ch + CHW'(1) : ch;
            if (step) shadow[ch] <= cur_dec ? bcd : hex_dig;
        end
    end

    // Blanking and font lookup happen only at commit, so the visible frame changes in one step.
    always_comb begin
        disp_d = disp;
        if (state == COMMIT)
            for (int c = 0; c < NCH; c++)
                for (int k = 0; k < DPC; k++)
                    disp_d[c*DPC+k] = (cur_lz && k > 0 && (shadow[c] >> (4*k)) == '0)
                                      ? SEG_BLANK : SEG_HEX[shadow[c][4*k +: 4]];
    end

    assign pos_d = (pre == PW'(SCAN_DIV - 1)) ? ((pos == DW'(ND - 1)) ? '0 : pos + DW'(1)) : pos;

    always_ff @(posedge clock) begin
        if (reset) begin
            pre     <= '0;
            pos     <= '0;
            seg_sel <= ND'(1);
            seg_out <= SEG_BLANK;
            for (int i = 0; i < ND; i++) disp[i] <= SEG_BLANK;
        end else begin
            pre     <= (pre == PW'(SCAN_DIV - 1)) ? '0 : pre + PW'(1);
            pos     <= pos_d;
            seg_sel <= ND'(1) << pos_d;
            seg_out <= disp_d[pos_d];
            disp    <= disp_d;
        end
    end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// tb_seg_display_ctrl: scoreboard of expected frames with due cycles; a negedge monitor
// checks the scanned digit every cycle, scenario tasks check busy timing inline.
module tb_seg_display_ctrl;

    localparam int W   = 16;
    localparam int NCH = 2;
    localparam int DPC = 5;
    localparam int SD  = 4;
    localparam int ND  = NCH * DPC;
    localparam int LH  = 3 + NCH;
    localparam int LD  = 3 + NCH * W;

    localparam logic [7:0] FONT [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

    typedef struct {
        int                due;
        logic [8*ND-1:0]   frame;
    } exp_t;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [NCH*W-1:0]   val_in = '0;
    logic               load = 1'b0;
    logic               dec_mode = 1'b0;
    logic               lz_blank = 1'b0;
    logic [7:0]         seg_out;
    logic [ND-1:0]      seg_sel;
    logic               busy;

    int                 cyc = 0;
    int                 vectors = 0;
    int                 miscompares = 0;
    logic               mon_en = 1'b0;
    logic [8*ND-1:0]    cur_frame = '0;
    exp_t               sbq[$];

    seg_display_ctrl #(.W(W), .NCH(NCH), .DPC(DPC), .SCAN_DIV(SD)) dut (
        .clock    (clock),
        .reset    (reset),
        .val_in   (val_in),
        .load     (load),
        .dec_mode (dec_mode),
        .lz_blank (lz_blank),
        .seg_out  (seg_out),
        .seg_sel  (seg_sel),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

    always @(negedge clock) begin
        if (mon_en) begin
            int p;
            logic [ND-1:0] es;
            while (sbq.size() > 0 && sbq[0].due <= cyc) cur_frame = sbq.pop_front().frame;
            p  = (cyc / SD) % ND;
            es = ND'(1) << p;
            vectors++;
            if (seg_sel !== es) begin
                miscompares++;
                $display("FAIL scan_sel cyc=%0d got=%b exp=%b", cyc, seg_sel, es);
            end
            vectors++;
            if (seg_out !== cur_frame[8*p +: 8]) begin
                miscompares++;
                $display("FAIL seg_out cyc=%0d digit=%0d got=%h exp=%h", cyc, p, seg_out, cur_frame[8*p +: 8]);
            end
        end
    end

    function automatic logic [8*ND-1:0] model(input logic [NCH*W-1:0] v, input logic d, input logic l);
        logic [8*ND-1:0] f;
        int x, hi;
        int dg [DPC];
        f = '0;
        for (int c = 0; c < NCH; c++) begin
            x  = int'(v[c*W +: W]);
            hi = 0;
            for (int k = 0; k < DPC; k++) begin
                dg[k] = d ? x % 10 : x % 16;
                x     = d ? x / 10 : x / 16;
                if (dg[k] != 0) hi = k;
            end
            for (int k = 0; k < DPC; k++)
                f[8*(c*DPC+k) +: 8] = (l && k > hi) ? 8'h00 : FONT[dg[k]];
        end
        return f;
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [NCH*W-1:0] v, input logic d, input logic l);
        val_in   = v;
        dec_mode = d;
        lz_blank = l;
        load     = 1'b1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        load  = 1'b0;
        tick;
        sbq.delete();
        cur_frame = '0;
        reset  = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_reset;
        logic [ND-1:0] es;
        do_reset;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy got=%b exp=0", busy);
        end
        vectors++;
        if (seg_sel !== ND'(1) || seg_out !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_out got sel=%b seg=%h exp sel=%b seg=00", seg_sel, seg_out, ND'(1));
        end
        repeat (3 * SD) tick;
        es = ND'(1) << 3;
        vectors++;
        if (seg_sel !== es || seg_out !== 8'h00) begin
            miscompares++;
            $display("FAIL idle_scan got sel=%b seg=%h exp sel=%b seg=00", seg_sel, seg_out, es);
        end
    endtask

    task automatic test_hex;
        sbq.push_back('{cyc + LH, {{5{8'h3F}}, 8'h3F, 8'h06, 8'h77, 8'h5B, 8'h71}});
        drive({16'h0000, 16'h1A2F}, 1'b0, 1'b0);
        for (int i = 1; i <= LH; i++) begin
            tick;
            load = 1'b0;
            vectors++;
            if (busy !== (i < LH)) begin
                miscompares++;
                $display("FAIL busy_hex step=%0d got=%b exp=%b", i, busy, i < LH);
            end
        end
        repeat (ND * SD) tick;
    endtask

    task automatic test_decimal;
        sbq.push_back('{cyc + LD, {8'h00, 8'h00, 8'h00, 8'h00, 8'h3F, 8'h7D, 8'h6D, 8'h6D, 8'h4F, 8'h6D}});
        drive({16'd0, 16'd65535}, 1'b1, 1'b1);
        for (int i = 1; i <= LD; i++) begin
            tick;
            load = 1'b0;
            vectors++;
            if (busy !== (i < LD)) begin
                miscompares++;
                $display("FAIL busy_dec step=%0d got=%b exp=%b", i, busy, i < LD);
            end
        end
        repeat (ND * SD) tick;
    endtask

    task automatic test_patterns;
        logic [NCH*W-1:0] v;
        logic d, l;
        int lat;
        for (int n = 0; n < 6; n++) begin
            v   = (n == 0) ? '0 : {16'($urandom), 16'($urandom_range(0, 255))};
            d   = n[0];
            l   = (n < 2) ? 1'b1 : 1'($urandom);
            lat = d ? LD : LH;
            sbq.push_back('{cyc + lat, model(v, d, l)});
            drive(v, d, l);
            for (int i = 1; i <= lat; i++) begin
                tick;
                load = 1'b0;
                vectors++;
                if (busy !== (i < lat)) begin
                    miscompares++;
                    $display("FAIL busy_pattern n=%0d step=%0d got=%b exp=%b", n, i, busy, i < lat);
                end
            end
            repeat (ND * SD) tick;
        end
    endtask

    task automatic test_back_to_back;
        logic [NCH*W-1:0] va, vb, vc;
        int end_c;
        va = {16'd4321, 16'd98};
        vb = {16'h8888, 16'h8888};
        vc = {16'h00C0, 16'h0007};
        end_c = LD + LH - 1;
        sbq.push_back('{cyc + LD, model(va, 1'b1, 1'b0)});
        sbq.push_back('{cyc + end_c, model(vc, 1'b0, 1'b1)});
        drive(va, 1'b1, 1'b0);
        for (int i = 1; i <= end_c; i++) begin
            tick;
            load = (i == 5 || i == 6);
            if (i == 5) drive(vb, 1'b0, 1'b0);
            if (i == 6) drive(vc, 1'b0, 1'b1);
            vectors++;
            if (busy !== (i < end_c)) begin
                miscompares++;
                $display("FAIL busy_b2b step=%0d got=%b exp=%b", i, busy, i < end_c);
            end
        end
        repeat (ND * SD) tick;
    endtask

    task automatic test_commit_load;
        logic [NCH*W-1:0] va, vb;
        int end_c;
        va = {16'hBEEF, 16'h0042};
        vb = {16'h0003, 16'hD00D};
        end_c = 2 * LH - 1;
        sbq.push_back('{cyc + LH, model(va, 1'b0, 1'b0)});
        sbq.push_back('{cyc + end_c, model(vb, 1'b0, 1'b1)});
        drive(va, 1'b0, 1'b0);
        for (int i = 1; i <= end_c; i++) begin
            tick;
            load = (i == LH - 1);
            if (i == LH - 1) drive(vb, 1'b0, 1'b1);
            vectors++;
            if (busy !== (i < end_c)) begin
                miscompares++;
                $display("FAIL busy_commit_load step=%0d got=%b exp=%b", i, busy, i < end_c);
            end
        end
        repeat (ND * SD) tick;
    endtask

    task automatic test_reset_mid;
        logic [NCH*W-1:0] v;
        drive({16'd1234, 16'd5678}, 1'b1, 1'b0);
        repeat (10) begin
            tick;
            load = 1'b0;
        end
        do_reset;
        vectors++;
        if (busy !== 1'b0 || seg_sel !== ND'(1) || seg_out !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_mid got busy=%b sel=%b seg=%h exp busy=0 sel=%b seg=00", busy, seg_sel, seg_out, ND'(1));
        end
        v = {16'h0F00, 16'h00A5};
        sbq.push_back('{cyc + LH, model(v, 1'b0, 1'b1)});
        drive(v, 1'b0, 1'b1);
        for (int i = 1; i <= LH; i++) begin
            tick;
            load = 1'b0;
            vectors++;
            if (busy !== (i < LH)) begin
                miscompares++;
                $display("FAIL busy_after_reset step=%0d got=%b exp=%b", i, busy, i < LH);
            end
        end
        repeat (ND * SD) tick;
        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL frames_left got=%0d exp=0", sbq.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        test_reset;
        test_hex;
        test_decimal;
        test_patterns;
        test_back_to_back;
        test_commit_load;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
